// File: rtl/key_conditioner_if.sv
// Key conditioner port bundle: raw key pins in, debounced levels, edge pulses
// and the SoC reset request out.
interface key_conditioner_if #(
  parameter int KEYS = 4
);
  logic [KEYS-1:0] io_key;
  logic [KEYS-1:0] io_keyLevel;
  logic [KEYS-1:0] io_keyPress;
  logic [KEYS-1:0] io_keyRelease;
  logic            io_sysReset;

  // Board / SoC side
  modport master (
    output io_key,
    input  io_keyLevel, io_keyPress, io_keyRelease, io_sysReset
  );

  // Conditioner side
  modport slave (
    input  io_key,
    output io_keyLevel, io_keyPress, io_keyRelease, io_sysReset
  );
endinterface

// File: rtl/key_conditioner.sv
// Push-button front end: synchronise, debounce, emit press/release pulses and
// a stretched SoC reset request from power-on or a long press of RESET_KEY.
module key_conditioner #(
  parameter int KEYS                 = 4,
  parameter bit KEY_ACTIVE_LOW       = 1'b1,
  parameter int DEBOUNCE_CYCLES      = 270000,
  parameter int RESET_KEY            = 3,
  parameter int RESET_HOLD_CYCLES    = 27000000,
  parameter int RESET_STRETCH_CYCLES = 1024
) (
  input  logic             io_mainClk,
  input  logic             io_asyncResetn,
  key_conditioner_if.slave bus
);
  localparam int DCW  = $clog2(DEBOUNCE_CYCLES);
  localparam int RMAX = (RESET_HOLD_CYCLES > RESET_STRETCH_CYCLES) ?
                        RESET_HOLD_CYCLES : RESET_STRETCH_CYCLES;
  localparam int RCW  = $clog2(RMAX);

  localparam logic [DCW-1:0] DB_LAST      = DCW'(DEBOUNCE_CYCLES - 1);
  localparam logic [RCW-1:0] HOLD_LAST    = RCW'(RESET_HOLD_CYCLES - 1);
  localparam logic [RCW-1:0] STRETCH_LAST = RCW'(RESET_STRETCH_CYCLES - 1);

  // Polarity is normalised before the synchroniser so every flop resets to "released".
  logic [KEYS-1:0] pressed_d;
  logic [KEYS-1:0] sync1_q, sync2_q;

  assign pressed_d = KEY_ACTIVE_LOW ? ~bus.io_key : bus.io_key;

  always_ff @(posedge io_mainClk or negedge io_asyncResetn) begin
    if (!io_asyncResetn) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= pressed_d;
      sync2_q <= sync1_q;
    end
  end

  logic [KEYS-1:0] level_vec, press_vec, release_vec;

  for (genvar gi = 0; gi < KEYS; gi++) begin : g_key
    logic [DCW-1:0] cnt_q;
    logic           level_q, press_q, release_q;

    always_ff @(posedge io_mainClk or negedge io_asyncResetn) begin
      if (!io_asyncResetn) begin
        cnt_q     <= '0;
        level_q   <= 1'b0;
        press_q   <= 1'b0;
        release_q <= 1'b0;
      end else begin
        press_q   <= 1'b0;
        release_q <= 1'b0;
        if (sync2_q[gi] == level_q) begin
          cnt_q <= '0;
        end else if (cnt_q == DB_LAST) begin
          cnt_q     <= '0;
          level_q   <= sync2_q[gi];
          press_q   <= sync2_q[gi];
          release_q <= ~sync2_q[gi];
        end else begin
          cnt_q <= cnt_q + 1'b1;
        end
      end
    end

    assign level_vec[gi]   = level_q;
    assign press_vec[gi]   = press_q;
    assign release_vec[gi] = release_q;
  end

  assign bus.io_keyLevel   = level_vec;
  assign bus.io_keyPress   = press_vec;
  assign bus.io_keyRelease = release_vec;

  typedef enum logic [1:0] {IDLE, HOLD, STRETCH, WAIT_RELEASE} rst_state_t;

  rst_state_t     state_q;
  logic [RCW-1:0] rcnt_q;
  logic           sys_reset_q;
  logic           hold_key;

  // The FSM watches the registered debounced level, so it lags key events by a cycle.
  assign hold_key = level_vec[RESET_KEY];

  always_ff @(posedge io_mainClk or negedge io_asyncResetn) begin
    if (!io_asyncResetn) begin
      state_q     <= STRETCH;
      rcnt_q      <= '0;
      sys_reset_q <= 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          if (hold_key) begin
            state_q <= HOLD;
            rcnt_q  <= '0;
          end
        end
        HOLD: begin
          if (!hold_key) begin
            state_q <= IDLE;
          end else if (rcnt_q == HOLD_LAST) begin
            state_q     <= STRETCH;
            rcnt_q      <= '0;
            sys_reset_q <= 1'b1;
          end else begin
            rcnt_q <= rcnt_q + 1'b1;
          end
        end
        STRETCH: begin
          if (rcnt_q == STRETCH_LAST) begin
            rcnt_q      <= '0;
            sys_reset_q <= 1'b0;
            state_q     <= hold_key ? WAIT_RELEASE : IDLE;
          end else begin
            rcnt_q <= rcnt_q + 1'b1;
          end
        end
        WAIT_RELEASE: begin
          if (!hold_key) state_q <= IDLE;
        end
        default: begin
          state_q     <= IDLE;
          sys_reset_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.io_sysReset = sys_reset_q;
endmodule

// File: tb/tb_key_conditioner.sv
// Randomised and directed bench for key_conditioner, checked every cycle
// against a run-length model of debounce and long-press reset.
module tb_key_conditioner;
  localparam int KEYS      = 4;
  localparam bit ACT_LOW   = 1'b1;
  localparam int DB        = 8;
  localparam int RKEY      = 3;
  localparam int HOLD      = 16;
  localparam int STRETCH   = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  key_conditioner_if #(.KEYS(KEYS)) bus ();

  key_conditioner #(
    .KEYS(KEYS), .KEY_ACTIVE_LOW(ACT_LOW), .DEBOUNCE_CYCLES(DB),
    .RESET_KEY(RKEY), .RESET_HOLD_CYCLES(HOLD), .RESET_STRETCH_CYCLES(STRETCH)
  ) dut (
    .io_mainClk(clk), .io_asyncResetn(rst_n), .bus(bus)
  );

  always #5 clk = ~clk;

  // Model: s is the normalised key seen two edges ago; a level flips on the
  // DB-th consecutive edge where s differs from it. Reset fires once the
  // registered reset-key level has been seen high on HOLD+1 consecutive edges.
  logic [KEYS-1:0] phist[$];
  int              run[KEYS];
  logic [KEYS-1:0] m_level, m_press, m_release;
  logic            m_sys;
  int              stretch_left, hold_run;
  bit              need_release;

  function automatic void model_reset();
    phist.delete();
    for (int k = 0; k < KEYS; k++) run[k] = 0;
    m_level = '0; m_press = '0; m_release = '0;
    m_sys = 1'b1; stretch_left = STRETCH; hold_run = 0; need_release = 0;
  endfunction

  function automatic void model_edge(input logic [KEYS-1:0] p);
    logic [KEYS-1:0] s;
    logic            l_old;
    l_old = m_level[RKEY];
    s = (phist.size() >= 2) ? phist[1] : '0;
    phist.push_front(p);
    if (phist.size() > 2) void'(phist.pop_back());
    if (stretch_left > 0) begin
      stretch_left--;
      hold_run = 0;
      if (stretch_left == 0) need_release = l_old;
    end else if (need_release) begin
      if (!l_old) need_release = 0;
    end else if (l_old) begin
      hold_run++;
      if (hold_run == HOLD + 1) begin
        stretch_left = STRETCH;
        hold_run = 0;
      end
    end else begin
      hold_run = 0;
    end
    m_sys = (stretch_left > 0);
    for (int k = 0; k < KEYS; k++) begin
      m_press[k] = 1'b0;
      m_release[k] = 1'b0;
      if (s[k] == m_level[k]) run[k] = 0;
      else begin
        run[k]++;
        if (run[k] == DB) begin
          m_level[k] = s[k];
          m_press[k] = s[k];
          m_release[k] = ~s[k];
          run[k] = 0;
        end
      end
    end
  endfunction

  function automatic logic [3*KEYS:0] dut_vec();
    return {bus.io_keyLevel, bus.io_keyPress, bus.io_keyRelease, bus.io_sysReset};
  endfunction

  function automatic logic [3*KEYS:0] exp_vec();
    return {m_level, m_press, m_release, m_sys};
  endfunction

  // Advance one edge; the model only moves while reset is released.
  task automatic tick();
    logic [KEYS-1:0] p;
    @(posedge clk);
    p = ACT_LOW ? ~bus.io_key : bus.io_key;
    if (rst_n) model_edge(p);
    #1;
  endtask

  task automatic test_reset();
    int hi;
    bus.io_key = '1;
    rst_n = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (dut_vec() !== 13'b0000_0000_0000_1)
      $display("FAIL reset_state got=%b want=%b", dut_vec(), 13'b0000_0000_0000_1);
    if (dut_vec() !== 13'b0000_0000_0000_1) errors++;
    #2 rst_n = 1'b1;
    hi = bus.io_sysReset ? 1 : 0;
    for (int i = 1; i <= 8; i++) begin
      tick();
      checks++;
      if (dut_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL por_cycle%0d got=%b want=%b", i, dut_vec(), exp_vec());
      end
      if (bus.io_sysReset) hi++;
    end
    checks++;
    if (hi !== STRETCH) begin
      errors++;
      $display("FAIL por_stretch_len got=%0d want=%0d", hi, STRETCH);
    end
  endtask

  task automatic test_clean_press();
    bus.io_key[0] = 1'b0;
    for (int i = 1; i <= 12; i++) begin
      tick();
      checks++;
      if (dut_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL press_cycle%0d got=%b want=%b", i, dut_vec(), exp_vec());
      end
      if (i == 10 || i == 11) begin
        checks++;
        if ({bus.io_keyLevel[0], bus.io_keyPress[0]} !== {1'b1, (i == 10)}) begin
          errors++;
          $display("FAIL press_edge%0d level/press got=%b%b want=1%b", i,
                   bus.io_keyLevel[0], bus.io_keyPress[0], (i == 10));
        end
      end
    end
    bus.io_key[0] = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      tick();
      checks++;
      if (dut_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL release_cycle%0d got=%b want=%b", i, dut_vec(), exp_vec());
      end
      if (i == 10) begin
        checks++;
        if ({bus.io_keyLevel[0], bus.io_keyRelease[0]} !== 2'b01) begin
          errors++;
          $display("FAIL release_edge level/release got=%b%b want=01",
                   bus.io_keyLevel[0], bus.io_keyRelease[0]);
        end
      end
    end
  endtask

  task automatic test_bounce();
    bit moved = 0;
    for (int i = 0; i < 45; i++) begin
      if (i < 30 && i % 3 == 0) bus.io_key[1] = ~bus.io_key[1];
      if (i == 30) bus.io_key[1] = 1'b1;
      tick();
      checks++;
      if (dut_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL bounce_cycle%0d got=%b want=%b", i, dut_vec(), exp_vec());
      end
      if (bus.io_keyLevel[1] || bus.io_keyPress[1] || bus.io_keyRelease[1]) moved = 1;
    end
    checks++;
    if (moved !== 1'b0) begin
      errors++;
      $display("FAIL bounce_quiet got=%b want=0", moved);
    end
  endtask

  task automatic test_long_press();
    for (int w = 0; w < 2; w++) begin
      int hi = 0;
      for (int i = 0; i < 60; i++) begin
        bus.io_key[RKEY] = (i < 40) ? 1'b0 : 1'b1;
        tick();
        checks++;
        if (dut_vec() !== exp_vec()) begin
          errors++;
          $display("FAIL long_w%0d_cycle%0d got=%b want=%b", w, i, dut_vec(), exp_vec());
        end
        if (bus.io_sysReset) hi++;
      end
      checks++;
      if (hi !== STRETCH) begin
        errors++;
        $display("FAIL long_w%0d_reset_len got=%0d want=%0d", w, hi, STRETCH);
      end
    end
  endtask

  task automatic test_short_press();
    int hi = 0;
    for (int i = 0; i < 45; i++) begin
      bus.io_key[RKEY] = (i < 14) ? 1'b0 : 1'b1;
      tick();
      checks++;
      if (dut_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL short_cycle%0d got=%b want=%b", i, dut_vec(), exp_vec());
      end
      if (bus.io_sysReset) hi++;
    end
    checks++;
    if (hi !== 0) begin
      errors++;
      $display("FAIL short_no_reset got=%0d want=0", hi);
    end
  endtask

  task automatic test_async_reset();
    bus.io_key[0] = 1'b0; bus.io_key[1] = 1'b0; bus.io_key[RKEY] = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      checks++;
      if (dut_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL midhold_cycle%0d got=%b want=%b", i, dut_vec(), exp_vec());
      end
    end
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    checks++;
    if (dut_vec() !== 13'b0000_0000_0000_1) begin
      errors++;
      $display("FAIL async_reset_now got=%b want=%b", dut_vec(), 13'b0000_0000_0000_1);
    end
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    for (int i = 1; i <= 60; i++) begin
      if (i == 45) bus.io_key = '1;
      tick();
      checks++;
      if (dut_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL after_reset_cycle%0d got=%b want=%b", i, dut_vec(), exp_vec());
      end
      if (i == 10) begin
        checks++;
        if (bus.io_keyLevel[1:0] !== 2'b11) begin
          errors++;
          $display("FAIL requalify got=%b want=11", bus.io_keyLevel[1:0]);
        end
      end
    end
  endtask

  task automatic test_random();
    int dwell[KEYS];
    for (int k = 0; k < KEYS; k++) dwell[k] = $urandom_range(1, 20);
    for (int i = 0; i < 2000; i++) begin
      for (int k = 0; k < KEYS; k++) begin
        if (dwell[k] == 0) begin
          bus.io_key[k] = ~bus.io_key[k];
          dwell[k] = (k == RKEY) ? $urandom_range(1, 60) : $urandom_range(1, 24);
        end else dwell[k]--;
      end
      if (i == 900 || i == 1500) begin
        #2 rst_n = 1'b0;
        model_reset();
        #1;
        checks++;
        if (dut_vec() !== exp_vec()) begin
          errors++;
          $display("FAIL rand_reset%0d got=%b want=%b", i, dut_vec(), exp_vec());
        end
        @(posedge clk);
        #3 rst_n = 1'b1;
      end
      tick();
      checks++;
      if (dut_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL rand_cycle%0d got=%b want=%b", i, dut_vec(), exp_vec());
      end
    end
  endtask

  initial begin
    bus.io_key = '1;
    model_reset();
    test_reset();
    test_clean_press();
    test_bounce();
    test_long_press();
    test_short_press();
    test_async_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
